// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state encoding and default sizes for the register file
package regfile_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;

endpackage

// File: rtl/regfile_bypass_if.sv
// rtl/regfile_bypass_if.sv - decode-side write/read bus of the register file
interface regfile_bypass_if
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] rd;
   logic [DATA_WIDTH-1:0] data;
   logic [ADDR_WIDTH-1:0] rs;
   logic [ADDR_WIDTH-1:0] rt;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  busy;

   modport master (output we, rd, data, rs, rt, input a, b, busy);
   modport slave  (input we, rd, data, rs, rt, output a, b, busy);
endinterface

// File: rtl/regfile_clear_ctrl.sv
// rtl/regfile_clear_ctrl.sv - post-reset clear sequencer and array write-port mux
module regfile_clear_ctrl
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] rd_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  busy_o,
   output logic                  run_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] clr_addr_q;
   logic                  busy_q;

   // Sequencer: walk every address once after reset, then hand the array to the datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_addr_q <= clr_addr_q + ONE;
               if (clr_addr_q == LAST_ADDR) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= ST_CLEAR;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // Write-port mux: zeros at the clear pointer while clearing, decode write when running
   always_comb begin
      wr_en_o   = 1'b0;
      wr_addr_o = rd_i;
      wr_data_o = data_i;
      if (!rst && state_q == ST_CLEAR) begin
         wr_en_o   = 1'b1;
         wr_addr_o = clr_addr_q;
         wr_data_o = '0;
      end else if (!rst && state_q == ST_RUN) begin
         wr_en_o = we_i && !((ZERO_REG != 0) && (rd_i == '0));
      end
   end

   assign busy_o = busy_q;
   assign run_o  = (state_q == ST_RUN);

endmodule

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - register file with registered read ports and write-to-read bypass
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic             clk,
   input  logic             rst,
   regfile_bypass_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] a_q, b_q, a_d, b_d;
   logic                  run;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   regfile_clear_ctrl #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_clear_ctrl (
      .clk       (clk),
      .rst       (rst),
      .we_i      (bus.we),
      .rd_i      (bus.rd),
      .data_i    (bus.data),
      .busy_o    (bus.busy),
      .run_o     (run),
      .wr_en_o   (wr_en),
      .wr_addr_o (wr_addr),
      .wr_data_o (wr_data)
   );

   // Storage array: no reset so it maps onto RAM; zeroing comes from the sequencer
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read muxes: zero register first, then same-cycle forwarding, then stored value
   always_comb begin
      a_d = mem_q[bus.rs];
      b_d = mem_q[bus.rt];
      if ((BYPASS != 0) && wr_en && (wr_addr == bus.rs)) a_d = wr_data;
      if ((BYPASS != 0) && wr_en && (wr_addr == bus.rt)) b_d = wr_data;
      if ((ZERO_REG != 0) && (bus.rs == '0)) a_d = '0;
      if ((ZERO_REG != 0) && (bus.rt == '0)) b_d = '0;
   end

   // Operand latches: held at zero until the array has been cleared
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   assign bus.a = a_q;
   assign bus.b = b_q;

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised register file for the MIPS datapath: one synchronous write port, two registered read ports (rs/rt to a/b), and a write-to-read bypass. It clears its storage with a built-in sequencer after reset, and can hardwire register 0 to zero. It sits between the decode stage (rs/rt/rd addresses) and the ALU operand latches, and is the single-edge, depth-generic successor of the current 16-entry register file.

## Interface
- DATA_WIDTH, 32, width of each register and of data/a/b
- ADDR_WIDTH, 5, address width; depth DEPTH = 2**ADDR_WIDTH (32 by default, full MIPS register set)
- ZERO_REG, 1, when 1, register 0 always reads zero and writes to it are discarded
- BYPASS, 1, when 1, a same-cycle write to the register being read is forwarded to a/b
- clk  input  1  clock; all state changes on rising edge only
- rst  input  1  synchronous, active-high reset
- we  input  1  write enable
- rd  input  ADDR_WIDTH  write address
- data  input  DATA_WIDTH  write data
- rs  input  ADDR_WIDTH  read address, port a
- rt  input  ADDR_WIDTH  read address, port b
- a  output  DATA_WIDTH  registered read data for rs
- b  output  DATA_WIDTH  registered read data for rt
- busy  output  1  high while the clear sequencer owns the array; writes are ignored and reads return 0

## Operation
- Two states: CLEAR and RUN.
- CLEAR: an internal counter clr_addr writes 0 to register[clr_addr] each cycle.
- rst=1: state forced to CLEAR, clr_addr forced to 0, a=b=0, busy=1. Reset values: a=0, b=0, busy=1.
- CLEAR with rst=0: increment clr_addr each cycle. When clr_addr = DEPTH-1 has been written, go to RUN and drop busy the next cycle.
- In CLEAR, we is ignored and a/b are driven to 0.
- RUN, write: when we=1 (and not (ZERO_REG && rd==0)), register[rd] <= data.
- RUN, read: a <= (ZERO_REG && rs==0) ? 0 : (BYPASS && we && rd==rs && !(ZERO_REG && rd==0)) ? data : register[rs]. Port b is identical with rt.
- With BYPASS=0, a same-cycle read returns the old contents.
- rs==rt is legal; a and b both get the same value.
- Storage uses no reset fanout on the array; clearing is done only by the sequencer, so the array can be inferred as RAM.

## Timing
- Read latency is 1 cycle: rs/rt are sampled at edge N, and a/b are valid after edge N.
- A write at edge N is visible to reads issued at edge N when BYPASS=1, otherwise from edge N+1.
- The clear takes exactly DEPTH cycles after the first edge with rst=0; busy falls after edge DEPTH. For DEPTH=32, busy is high for 32 cycles after rst drops.
- Reset mid-clear restarts clr_addr at 0, so the full DEPTH cycles follow again.
- Reset in RUN re-enters CLEAR on the same edge.
- Writes presented while busy=1 are dropped, not queued. Upstream stalls on busy.
- The first write is accepted on the edge where busy is already 0.

## Structure
- A shared package/header regfile_pkg holds:
  - the state encoding (ST_CLEAR, ST_RUN)
  - default DATA_WIDTH/ADDR_WIDTH constants
- One sub-module, regfile_clear_ctrl, contains the state register, clr_addr counter and busy output. It drives the array's write mux (clear address/zero data vs rd/data).
- The top module contains the array, the bypass/zero-register read muxes and the output registers.

## Test plan
- Reset then idle: hold rst 3 cycles, release → busy=1 for exactly 32 cycles, then busy=0; reads of all 32 registers return 0.
- Basic write/read: write 0xDEADBEEF to r5, next cycle rs=5 → a=0xDEADBEEF one cycle later; b with rt=5 matches.
- Bypass: we=1, rd=7, data=0x12345678 with rs=7, rt=7 in the same cycle → a=b=0x12345678 after that edge. With BYPASS=0, both read the prior value 0.
- Zero register: write 0xFFFFFFFF to r0 → reads of r0 return 0 both on the bypass cycle and later.
- Write during clear: we=1, rd=3, data=0xA5A5A5A5 while busy=1 → after clear, r3 reads 0.
- Reset mid-clear and in RUN:
  - assert rst at clear cycle 10 → busy stays high 32 more cycles after release.
  - with r9=0x55 in RUN, pulse rst → r9 reads 0 after the clear completes.
